// File: rtl/key_sequence_loader_pkg.sv
// ---------------------------------------------------------------------------
// key_sequence_loader_pkg
// Shared types for the key-delivery stage of the time-varying logic-locked
// cores.
//   state_t    : loader FSM states (IDLE / LOAD / ARMED / RUN)
//   key_word_t : one schedule word at the default key width
//   DEF_*      : default schedule geometry
// ---------------------------------------------------------------------------
package key_sequence_loader_pkg;

  localparam int DEF_NUM_KEYS = 4;
  localparam int DEF_KEY_W    = 3;

  typedef logic [DEF_KEY_W-1:0] key_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

endpackage

// File: rtl/key_sequence_loader_if.sv
// ---------------------------------------------------------------------------
// key_sequence_loader_if
// Bit-serial key load link.
//   ld_valid : a key bit is present on ld_data
//   ld_data  : key bit, word 0 first, LSB first within each word
//   ld_ready : loader accepts a bit this cycle
//   ld_abort : discard any partial/complete load and return to IDLE
//
// Handshake: a beat transfers on every rising edge where ld_valid and
// ld_ready are both high. ld_ready depends only on loader state, never on
// ld_valid. A bit offered while ld_ready is low is dropped, not held; the
// sender owns retrying it.
// ---------------------------------------------------------------------------
interface key_sequence_loader_if;

  logic ld_valid;
  logic ld_data;
  logic ld_ready;
  logic ld_abort;

  modport master (
    output ld_valid,
    output ld_data,
    output ld_abort,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    input  ld_abort,
    output ld_ready
  );

endinterface

// File: rtl/key_sched_regfile.sv
// ---------------------------------------------------------------------------
// key_sched_regfile
// NUM_KEYS x KEY_W key schedule storage.
//   clock, reset_n : clock, asynchronous active-low reset (storage -> 0)
//   clr            : synchronous clear of every word (wins over we)
//   we             : write one bit: mem[wr_word][wr_bit] <= wr_data
//   rd_idx         : combinational read index (schedule slot)
//   rd_data        : word at rd_idx
// ---------------------------------------------------------------------------
module key_sched_regfile #(
  parameter int NUM_KEYS = 4,
  parameter int KEY_W    = 3,
  parameter int IDX_W    = $clog2(NUM_KEYS),
  parameter int BIT_W    = (KEY_W > 1) ? $clog2(KEY_W) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_word,
  input  logic [BIT_W-1:0] wr_bit,
  input  logic             wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [KEY_W-1:0] rd_data
);

  logic [KEY_W-1:0] mem [NUM_KEYS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_KEYS; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_KEYS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_word][wr_bit] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/key_sequence_loader.sv
// ---------------------------------------------------------------------------
// key_sequence_loader
// Receives a NUM_KEYS x KEY_W key schedule over a bit-serial link, stores
// it, and on start plays it onto the core key inputs one word per clock,
// stepping the phase in lockstep with the core's key-phase counter.
//
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   ld             : serial load link (slave side, see key_sequence_loader_if)
//   start          : begin driving the schedule from ARMED (pulse)
//   resync         : force phase to 0 on the next edge while running (pulse)
//   stop           : leave RUN and return to ARMED (pulse)
//   key_out        : registered key word to the core, 0 outside RUN
//   phase          : registered current schedule slot, 0 outside RUN
//   loaded         : a complete schedule is held
//   running        : registered, high in RUN
//   load_err       : sticky, start seen in IDLE or LOAD; cleared by ld_abort
//   dbg_state      : current FSM state
// ---------------------------------------------------------------------------
module key_sequence_loader
  import key_sequence_loader_pkg::*;
#(
  parameter int NUM_KEYS = DEF_NUM_KEYS,
  parameter int KEY_W    = DEF_KEY_W,
  parameter int PH_W     = $clog2(NUM_KEYS)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  key_sequence_loader_if.slave ld,
  input  logic                 start,
  input  logic                 resync,
  input  logic                 stop,
  output logic [KEY_W-1:0]     key_out,
  output logic [PH_W-1:0]      phase,
  output logic                 loaded,
  output logic                 running,
  output logic                 load_err,
  output state_t               dbg_state
);

  localparam int TOTAL_BITS = NUM_KEYS * KEY_W;
  localparam int BEAT_W     = $clog2(TOTAL_BITS + 1);
  localparam int BIT_W      = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  state_t            state, state_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_nxt;
  logic              loaded_nxt;
  logic              err_nxt;
  logic [PH_W-1:0]   phase_nxt;
  logic              running_nxt;
  logic [KEY_W-1:0]  key_nxt;

  logic              abort_eff;
  logic              accept;
  logic              last_beat;
  logic              realign;
  logic [PH_W-1:0]   wr_word;
  logic [BIT_W-1:0]  wr_bit;
  logic [KEY_W-1:0]  rd_data;

  // Ready is purely a function of state so the sender never sees a
  // combinational path from its own valid.
  assign ld.ld_ready = (state == ST_IDLE) || (state == ST_LOAD);

  // Abort is honoured everywhere except RUN, and it overrides a beat
  // arriving in the same cycle.
  assign abort_eff = ld.ld_abort && (state != ST_RUN);
  assign accept    = ld.ld_valid && ld.ld_ready && !abort_eff;
  assign last_beat = accept && (beat_cnt == BEAT_W'(TOTAL_BITS - 1));

  // Beat n lands in bit (n mod KEY_W) of word (n / KEY_W).
  assign wr_word = PH_W'(int'(beat_cnt) / KEY_W);
  assign wr_bit  = BIT_W'(int'(beat_cnt) % KEY_W);

  // A start while already running restarts the schedule like resync.
  assign realign = resync || start;

  key_sched_regfile #(
    .NUM_KEYS (NUM_KEYS),
    .KEY_W    (KEY_W),
    .IDX_W    (PH_W),
    .BIT_W    (BIT_W)
  ) u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (abort_eff),
    .we      (accept),
    .wr_word (wr_word),
    .wr_bit  (wr_bit),
    .wr_data (ld.ld_data),
    .rd_idx  (phase_nxt),
    .rd_data (rd_data)
  );

  // Next-state, counters and registered-output precompute.
  always_comb begin
    state_nxt   = state;
    beat_nxt    = beat_cnt;
    loaded_nxt  = loaded;
    err_nxt     = load_err;
    phase_nxt   = '0;
    running_nxt = 1'b0;
    key_nxt     = '0;

    unique case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort_eff)      state_nxt = ST_IDLE;
        else if (last_beat) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (abort_eff)  state_nxt = ST_IDLE;
        else if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (stop) state_nxt = ST_ARMED;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (abort_eff) begin
      beat_nxt   = '0;
      loaded_nxt = 1'b0;
    end else if (accept) begin
      beat_nxt = beat_cnt + BEAT_W'(1);
      if (last_beat) loaded_nxt = 1'b1;
    end

    if (abort_eff) begin
      err_nxt = 1'b0;
    end else if (start && ((state == ST_IDLE) || (state == ST_LOAD))) begin
      err_nxt = 1'b1;
    end

    // Phase advances only while staying in RUN without a realign request;
    // entering RUN or realigning restarts at slot 0. NUM_KEYS is a power
    // of two, so the natural wrap of the counter is the schedule wrap.
    if (state_nxt == ST_RUN) begin
      running_nxt = 1'b1;
      if ((state == ST_RUN) && !realign) phase_nxt = phase + PH_W'(1);
      else                               phase_nxt = '0;
      key_nxt = rd_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      loaded   <= 1'b0;
      load_err <= 1'b0;
      phase    <= '0;
      running  <= 1'b0;
      key_out  <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
      loaded   <= loaded_nxt;
      load_err <= err_nxt;
      phase    <= phase_nxt;
      running  <= running_nxt;
      key_out  <= key_nxt;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_key_sequence_loader.sv
// ---------------------------------------------------------------------------
// tb_key_sequence_loader
// Directed bench for key_sequence_loader at default geometry (4 x 3 bits).
// Inputs change and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_key_sequence_loader;
  import key_sequence_loader_pkg::*;

  // Flat schedule, beat i is bit i: {w3, w2, w1, w0}.
  localparam logic [11:0] SCHED = {3'b001, 3'b111, 3'b010, 3'b101};
  localparam logic [11:0] ONES  = 12'hFFF;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       resync;
  logic       stop;
  logic [2:0] key_out;
  logic [1:0] phase;
  logic       loaded;
  logic       running;
  logic       load_err;
  state_t     dbg_state;

  int checks;
  int failures;

  key_sequence_loader_if ld_if ();

  key_sequence_loader dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ld        (ld_if.slave),
    .start     (start),
    .resync    (resync),
    .stop      (stop),
    .key_out   (key_out),
    .phase     (phase),
    .loaded    (loaded),
    .running   (running),
    .load_err  (load_err),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_beats(input int first, input int count, input logic [11:0] bits);
    for (int i = first; i < first + count; i++) begin
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = bits[i];
      tick();
    end
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = 1'b0;
  endtask

  task automatic pulse_abort();
    ld_if.ld_abort = 1'b1;
    tick();
    ld_if.ld_abort = 1'b0;
  endtask

  // Starts from ARMED, checks six RUN cycles, then stops back to ARMED.
  task automatic run_sequence(input string tag, input logic [11:0] bits);
    logic [2:0] exp_w;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_w = bits[(k % 4) * 3 +: 3];
      checks++;
      if ({running, phase, key_out} !== {1'b1, 2'(k % 4), exp_w}) begin
        $display("FAIL %s_run_k%0d: running/phase/key=%b/%0d/%b required 1/%0d/%b",
                 tag, k, running, phase, key_out, k % 4, exp_w);
        failures++;
      end
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if ({dbg_state, running, key_out, loaded} !== {ST_ARMED, 1'b0, 3'b000, 1'b1}) begin
      $display("FAIL %s_stop: state/running/key/loaded=%0d/%b/%b/%b required %0d/0/000/1",
               tag, dbg_state, running, key_out, loaded, ST_ARMED);
      failures++;
    end
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    start          = 1'b0;
    resync         = 1'b0;
    stop           = 1'b0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = 1'b0;
    ld_if.ld_abort = 1'b0;
    tick();
    tick();
    checks++;
    if ({key_out, phase, loaded, running, load_err} !== 8'b0) begin
      $display("FAIL reset_outputs: key/phase/loaded/running/err=%b/%0d/%b/%b/%b required all 0",
               key_out, phase, loaded, running, load_err);
      failures++;
    end
    checks++;
    if ({dbg_state, ld_if.ld_ready} !== {ST_IDLE, 1'b1}) begin
      $display("FAIL reset_state: state/ready=%0d/%b required %0d/1",
               dbg_state, ld_if.ld_ready, ST_IDLE);
      failures++;
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_load();
    load_beats(0, 11, SCHED);
    checks++;
    if ({dbg_state, loaded, ld_if.ld_ready} !== {ST_LOAD, 1'b0, 1'b1}) begin
      $display("FAIL basic_beat11: state/loaded/ready=%0d/%b/%b required %0d/0/1",
               dbg_state, loaded, ld_if.ld_ready, ST_LOAD);
      failures++;
    end
    load_beats(11, 1, SCHED);
    checks++;
    if ({dbg_state, loaded, ld_if.ld_ready} !== {ST_ARMED, 1'b1, 1'b0}) begin
      $display("FAIL basic_beat12: state/loaded/ready=%0d/%b/%b required %0d/1/0",
               dbg_state, loaded, ld_if.ld_ready, ST_ARMED);
      failures++;
    end
    // A beat offered while ARMED is dropped and must not disturb storage.
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = 1'b0;
    tick();
    ld_if.ld_valid = 1'b0;
    checks++;
    if ({dbg_state, ld_if.ld_ready, key_out} !== {ST_ARMED, 1'b0, 3'b000}) begin
      $display("FAIL armed_drop: state/ready/key=%0d/%b/%b required %0d/0/000",
               dbg_state, ld_if.ld_ready, key_out, ST_ARMED);
      failures++;
    end
    run_sequence("basic", SCHED);
  endtask

  task automatic test_toggle_load();
    pulse_abort();
    checks++;
    if ({dbg_state, loaded} !== {ST_IDLE, 1'b0}) begin
      $display("FAIL toggle_abort: state/loaded=%0d/%b required %0d/0",
               dbg_state, loaded, ST_IDLE);
      failures++;
    end
    for (int c = 0; c < 23; c++) begin
      ld_if.ld_valid = (c % 2 == 0);
      ld_if.ld_data  = (c % 2 == 0) ? SCHED[c / 2] : 1'b1;
      tick();
      if (c == 21) begin
        checks++;
        if (loaded !== 1'b0) begin
          $display("FAIL toggle_early: loaded=%b after 22 cycles required 0", loaded);
          failures++;
        end
      end
    end
    ld_if.ld_valid = 1'b0;
    checks++;
    if ({dbg_state, loaded} !== {ST_ARMED, 1'b1}) begin
      $display("FAIL toggle_done: state/loaded=%0d/%b after 23 cycles required %0d/1",
               dbg_state, loaded, ST_ARMED);
      failures++;
    end
    run_sequence("toggle", SCHED);
  endtask

  task automatic test_abort();
    pulse_abort();
    load_beats(0, 7, SCHED);
    checks++;
    if (dbg_state !== ST_LOAD) begin
      $display("FAIL abort_pre: state=%0d required %0d", dbg_state, ST_LOAD);
      failures++;
    end
    // Abort coincides with a valid beat: abort must win.
    ld_if.ld_abort = 1'b1;
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = 1'b1;
    tick();
    ld_if.ld_abort = 1'b0;
    ld_if.ld_valid = 1'b0;
    checks++;
    if ({dbg_state, loaded, ld_if.ld_ready} !== {ST_IDLE, 1'b0, 1'b1}) begin
      $display("FAIL abort_mid: state/loaded/ready=%0d/%b/%b required %0d/0/1",
               dbg_state, loaded, ld_if.ld_ready, ST_IDLE);
      failures++;
    end
    load_beats(0, 12, ONES);
    checks++;
    if ({dbg_state, loaded} !== {ST_ARMED, 1'b1}) begin
      $display("FAIL abort_reload: state/loaded=%0d/%b required %0d/1",
               dbg_state, loaded, ST_ARMED);
      failures++;
    end
    run_sequence("ones", ONES);
  endtask

  task automatic test_load_err();
    pulse_abort();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({dbg_state, load_err} !== {ST_IDLE, 1'b1}) begin
      $display("FAIL err_idle: state/err=%0d/%b required %0d/1", dbg_state, load_err, ST_IDLE);
      failures++;
    end
    pulse_abort();
    checks++;
    if (load_err !== 1'b0) begin
      $display("FAIL err_clear_idle: err=%b required 0", load_err);
      failures++;
    end
    load_beats(0, 5, SCHED);
    // Beat 5 carries a start: beat is still stored, start only flags error.
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = SCHED[5];
    start          = 1'b1;
    tick();
    start          = 1'b0;
    ld_if.ld_valid = 1'b0;
    checks++;
    if ({dbg_state, load_err, running} !== {ST_LOAD, 1'b1, 1'b0}) begin
      $display("FAIL err_load: state/err/running=%0d/%b/%b required %0d/1/0",
               dbg_state, load_err, running, ST_LOAD);
      failures++;
    end
    load_beats(6, 6, SCHED);
    checks++;
    if ({dbg_state, loaded, load_err} !== {ST_ARMED, 1'b1, 1'b1}) begin
      $display("FAIL err_armed: state/loaded/err=%0d/%b/%b required %0d/1/1",
               dbg_state, loaded, load_err, ST_ARMED);
      failures++;
    end
    run_sequence("err", SCHED);
    checks++;
    if (load_err !== 1'b1) begin
      $display("FAIL err_sticky: err=%b required 1", load_err);
      failures++;
    end
    pulse_abort();
    checks++;
    if ({dbg_state, load_err, loaded} !== {ST_IDLE, 1'b0, 1'b0}) begin
      $display("FAIL err_abort: state/err/loaded=%0d/%b/%b required %0d/0/0",
               dbg_state, load_err, loaded, ST_IDLE);
      failures++;
    end
  endtask

  task automatic test_resync();
    load_beats(0, 12, SCHED);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if ({phase, key_out} !== {2'd2, 3'b111}) begin
      $display("FAIL resync_pre: phase/key=%0d/%b required 2/111", phase, key_out);
      failures++;
    end
    resync = 1'b1;
    tick();
    resync = 1'b0;
    checks++;
    if ({phase, key_out} !== {2'd0, 3'b101}) begin
      $display("FAIL resync_apply: phase/key=%0d/%b required 0/101", phase, key_out);
      failures++;
    end
    tick();
    checks++;
    if ({phase, key_out} !== {2'd1, 3'b010}) begin
      $display("FAIL resync_after: phase/key=%0d/%b required 1/010", phase, key_out);
      failures++;
    end
    // start while running behaves as resync.
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({dbg_state, phase, key_out, load_err} !== {ST_RUN, 2'd0, 3'b101, 1'b0}) begin
      $display("FAIL run_start: state/phase/key/err=%0d/%0d/%b/%b required %0d/0/101/0",
               dbg_state, phase, key_out, load_err, ST_RUN);
      failures++;
    end
    tick();
    stop   = 1'b1;
    resync = 1'b1;
    tick();
    stop   = 1'b0;
    resync = 1'b0;
    checks++;
    if ({dbg_state, key_out, running} !== {ST_ARMED, 3'b000, 1'b0}) begin
      $display("FAIL stop_resync: state/key/running=%0d/%b/%b required %0d/000/0",
               dbg_state, key_out, running, ST_ARMED);
      failures++;
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if ({running, key_out} !== {1'b1, 3'b010}) begin
      $display("FAIL areset_pre: running/key=%b/%b required 1/010", running, key_out);
      failures++;
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({key_out, running, phase} !== 6'b0) begin
      $display("FAIL areset_immediate: key/running/phase=%b/%b/%0d required 000/0/0",
               key_out, running, phase);
      failures++;
    end
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if ({dbg_state, loaded, ld_if.ld_ready, key_out} !== {ST_IDLE, 1'b0, 1'b1, 3'b000}) begin
      $display("FAIL areset_after: state/loaded/ready/key=%0d/%b/%b/%b required %0d/0/1/000",
               dbg_state, loaded, ld_if.ld_ready, key_out, ST_IDLE);
      failures++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_load();
    test_toggle_load();
    test_abort();
    test_load_err();
    test_resync();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
